// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiplier FSM states, Booth digit encoding, default datapath width.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Sequencer states of the Booth multiplier.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // Radix-4 Booth digit selected by one multiplier triplet.
    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_POS1 = 3'd1,
        DIG_POS2 = 3'd2,
        DIG_NEG1 = 3'd3,
        DIG_NEG2 = 3'd4
    } booth_digit_t;

    // Triplet {b[2i+1], b[2i], b[2i-1]} -> digit = -2*b[2i+1] + b[2i] + b[2i-1].
    function automatic booth_digit_t booth_decode(input logic [2:0] trip);
        booth_digit_t dig;
        case (trip)
            3'b001, 3'b010: dig = DIG_POS1;
            3'b011:         dig = DIG_POS2;
            3'b100:         dig = DIG_NEG2;
            3'b101, 3'b110: dig = DIG_NEG1;
            default:        dig = DIG_ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps one multiplier triplet to neg/zero/two select flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the triplet.
// Ports: triplet (in, 3) -> neg (digit is negative), zero (digit is 0), two (|digit| is 2).
module booth_recoder
    import cpu_pkg::*;
(
    input  logic [2:0] triplet,
    output logic       neg,
    output logic       zero,
    output logic       two
);

    booth_digit_t digit;

    always_comb begin
        digit = booth_decode(triplet);
        neg   = 1'b0;
        zero  = 1'b0;
        two   = 1'b0;
        case (digit)
            DIG_POS1: begin end
            DIG_POS2: two = 1'b1;
            DIG_NEG1: neg = 1'b1;
            DIG_NEG2: begin
                neg = 1'b1;
                two = 1'b1;
            end
            default:  zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/booth_mul_unit.sv
// Sequential signed radix-4 Booth multiplier producing a 2*WIDTH product for Zhigh/Zlow.
// Latency: start sampled at edge 0, done pulses after edge WIDTH/2; one op per WIDTH/2+2 cycles.
// Backpressure: start accepted only in IDLE; start during RUN/DONE is dropped, not queued.
// Ports: clk, clr (sync active-high); start, multiplicand (A, from Y), multiplier (B, from bus);
//        busy (high in RUN), done (1-cycle pulse), product_hi/product_lo (registered result).
module booth_mul_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS) + 1;
    // Upper accumulator carries two guard bits so that +-2A never overflows.
    localparam int AW    = WIDTH + 2;

    mul_state_t       state;
    logic [CW-1:0]    step_cnt;
    logic [WIDTH-1:0] a_reg;
    // Multiplier with the implicit b[-1]=0 appended; shifts right by 2 each step
    // so the active triplet is always b_sh[2:0].
    logic [WIDTH:0]   b_sh;
    logic [AW-1:0]    acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             dig_neg;
    logic             dig_zero;
    logic             dig_two;
    logic [AW-1:0]    mag;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    sum;
    logic [AW-1:0]    nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic             last_step;

    booth_recoder u_recoder (
        .triplet (b_sh[2:0]),
        .neg     (dig_neg),
        .zero    (dig_zero),
        .two     (dig_two)
    );

    always_comb begin
        mag    = '0;
        addend = '0;
        sum    = '0;
        nxt_hi = '0;
        nxt_lo = '0;
        // |digit|*A, sign-extended to the accumulator width.
        if (dig_two) begin
            mag = {a_reg[WIDTH-1], a_reg, 1'b0};
        end else begin
            mag = {{2{a_reg[WIDTH-1]}}, a_reg};
        end
        if (dig_zero) begin
            addend = '0;
        end else if (dig_neg) begin
            addend = (~mag) + AW'(1);
        end else begin
            addend = mag;
        end
        sum = acc_hi + addend;
        // Arithmetic shift of {acc_hi, acc_lo} right by 2: the two retired low
        // bits of the upper half drop into the lower half.
        nxt_hi = {{2{sum[AW-1]}}, sum[AW-1:2]};
        nxt_lo = {sum[1:0], acc_lo[WIDTH-1:2]};
    end

    assign last_step = (step_cnt == CW'(STEPS - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
            step_cnt   <= '0;
            a_reg      <= '0;
            b_sh       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg    <= multiplicand;
                        b_sh     <= {multiplier, 1'b0};
                        acc_hi   <= '0;
                        acc_lo   <= '0;
                        step_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_hi   <= nxt_hi;
                    acc_lo   <= nxt_lo;
                    b_sh     <= {b_sh[WIDTH], b_sh[WIDTH], b_sh[WIDTH:2]};
                    step_cnt <= step_cnt + CW'(1);
                    if (last_step) begin
                        // Guard bits are pure sign extension here; the exact
                        // product is the low WIDTH bits of the upper half.
                        product_hi <= nxt_hi[WIDTH-1:0];
                        product_lo <= nxt_lo;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_unit.sv
// Directed bench for booth_mul_unit: vector table of signed products plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_booth_mul_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic         busy;
    logic         done;
    logic [W-1:0] product_hi;
    logic [W-1:0] product_lo;

    int checks   = 0;
    int failures = 0;

    int overlap_cnt = 0;
    int dbl_done    = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    booth_mul_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    // Watch the whole run for busy/done overlap and stretched done pulses.
    always @(negedge clk) begin
        if (busy === 1'b1 && done === 1'b1) overlap_cnt++;
        if (done === 1'b1 && done_prev === 1'b1) dbl_done++;
        done_prev = done;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full multiply: start sampled at edge 0, done expected right after edge W/2
    // with busy high for the W/2 cycles in between.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] hi, input logic [W-1:0] lo,
                           input string name);
        int busy_cnt;
        int done_edge;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        start     = 1'b0;
        busy_cnt  = 0;
        done_edge = -1;
        for (int e = 1; e <= 40; e++) begin
            if (busy) busy_cnt++;
            tick();
            if (done) begin
                done_edge = e;
                break;
            end
        end
        chk({name, "_latency"}, 64'(done_edge), 64'(W / 2));
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W / 2));
        chk({name, "_product"}, {product_hi, product_lo}, {hi, lo});
        tick();
    endtask

    vec_t vecs[12];

    initial begin
        int dcount;
        int first_e;
        int second_e;
        int lo_bad;
        int late_done;
        int held_bad;
        int got;

        vecs[0]  = '{32'h0000_0004, 32'h0000_0005, 32'h0000_0000, 32'h0000_0014};
        vecs[1]  = '{32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[6]  = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000};
        vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[8]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[9]  = '{32'hFFFF_FFFE, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[10] = '{32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[11] = '{32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

        clr          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", {product_hi, product_lo}, 64'd0);
        clr = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
        end

        // Operands are captured at start; the last table result must hold until done.
        multiplicand = 32'h18;
        multiplier   = 32'h0C;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'h55AA_55AA;
        held_bad     = 0;
        got          = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (done) begin
                got = 1;
                break;
            end
            if ({product_hi, product_lo} !== 64'h0000_0001_2345_6780) held_bad++;
        end
        chk("stable_done_seen", 64'(got), 64'd1);
        chk("stable_prev_held", 64'(held_bad), 64'd0);
        chk("stable_product", {product_hi, product_lo}, 64'h0000_0000_0000_0120);
        tick();
        tick();

        // Start pulses in RUN and in the DONE cycle are dropped.
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = 32'd1;
        multiplier   = 32'd1;
        for (int e = 0; e < 4; e++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        got   = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (done) begin
                got = 1;
                break;
            end
        end
        chk("ignore_done_seen", 64'(got), 64'd1);
        chk("ignore_product", {product_hi, product_lo}, 64'd81);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignore_done_start_busy", 64'(busy), 64'd0);
        late_done = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (busy || done) late_done++;
        end
        chk("ignore_no_extra_op", 64'(late_done), 64'd0);

        // Mid-operation clear after step 8.
        multiplicand = 32'h7FFF_FFFF;
        multiplier   = 32'd3;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 8; e++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_product", {product_hi, product_lo}, 64'd0);
        late_done = 0;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (done || busy) late_done++;
        end
        chk("clr_no_done", 64'(late_done), 64'd0);
        run_mul(32'd6, 32'd7, 32'd0, 32'd42, "after_clr");

        // start held for 40 cycles: ops at edges 0 and 18, done at 16 and 34.
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        start        = 1'b1;
        dcount       = 0;
        first_e      = -1;
        second_e     = -1;
        lo_bad       = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (done) begin
                dcount++;
                if (product_lo !== 32'd6) lo_bad++;
                if (first_e < 0) first_e = e;
                else if (second_e < 0) second_e = e;
            end
        end
        start = 1'b0;
        chk("held_done_count", 64'(dcount), 64'd2);
        chk("held_done_first", 64'(first_e), 64'(W / 2));
        chk("held_done_spacing", 64'(second_e - first_e), 64'(W / 2 + 2));
        chk("held_product_lo", 64'(lo_bad), 64'd0);
        for (int e = 0; e < 40; e++) begin
            tick();
            if (done) break;
        end
        tick();

        chk("busy_done_overlap", 64'(overlap_cnt), 64'd0);
        chk("done_two_cycles", 64'(dbl_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
